arbiter_merge_n: RTL

ARBITER_MERGE_N -- requirements
Module: arbiter_merge_n

---
 rtl/arb_merge_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/arbiter_merge_n.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arb_merge_pkg.sv
// Shared types, defaults and the round-robin pick helper for arbiter_merge_n.
package arb_merge_pkg;

   localparam int ARB_MERGE_WIDTH  = 33;
   localparam int ARB_MERGE_NUM_IN = 4;
   localparam int RR_MAX_N         = 16;

   typedef enum logic {ARB, LOCK} arb_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of req at or after ptr, searching upward with wrap.
   // Unused upper request bits must be zero, so the 16-wide wrap behaves
   // exactly like a wrap at the real port count.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                        input logic [3:0]          ptr);
      rr_pick_t   res;
      logic [3:0] cand;
      res = '0;
      for (int k = 0; k < RR_MAX_N; k++) begin
         cand = ptr + 4'(k);
         if (!res.valid && req[cand]) begin
            res.valid = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter built on arb_merge_pkg::rr_pick.
module rr_arbiter
   import arb_merge_pkg::*;
#(
   parameter int N = 4,
   localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            grant_valid,
   output logic [IDXW-1:0] grant_idx
);

   logic [RR_MAX_N-1:0] req_ext;
   rr_pick_t            pick;

   // Widen the request vector and select the winner.
   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      pick           = rr_pick(req_ext, 4'(ptr));
      grant_valid    = pick.valid;
      grant_idx      = pick.idx[IDXW-1:0];
   end

endmodule

// File: rtl/arbiter_merge_n.sv
// N-to-1 round-robin flit merger with a single registered output stage.
// Optional packet lock (whole packet from one source) when the macro
// ARB_MERGE_PKT_LOCK_EN is defined; otherwise every flit is arbitrated alone.
module arbiter_merge_n
   import arb_merge_pkg::*;
#(
   parameter int NUM_IN = ARB_MERGE_NUM_IN,
   parameter int WIDTH  = ARB_MERGE_WIDTH,
   localparam int SRC_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [SRC_W-1:0]        out_src
);

   logic              stage_free;
   logic              grant_valid;
   logic [SRC_W-1:0]  grant_idx;
   logic              xfer;
   logic              ptr_advance;
   logic [NUM_IN-1:0] req;
   logic [SRC_W-1:0]  ptr_inc;
   logic [SRC_W-1:0]  prio_ptr_q, prio_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;
   logic [WIDTH-1:0]  data_arr [NUM_IN];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_port
         assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
         assign in_ready[gi] = !reset && xfer && (grant_idx == SRC_W'(gi));
      end
   endgenerate

   rr_arbiter #(.N(NUM_IN)) u_rr (
      .req         (req),
      .ptr         (prio_ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign stage_free = !out_valid_q || out_ready;
   assign xfer       = stage_free && grant_valid;
   assign ptr_inc    = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + SRC_W'(1);

`ifdef ARB_MERGE_PKT_LOCK_EN
   arb_state_t       state_q, state_d;
   logic [SRC_W-1:0] lock_src_q, lock_src_d;

   // State register: current mode and the source holding the lock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARB;
         lock_src_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= lock_src_d;
      end
   end

   // Next state: lock on a non-final flit, release on the final one.
   always_comb begin
      state_d    = state_q;
      lock_src_d = lock_src_q;
      case (state_q)
         ARB: if (xfer && !in_last[grant_idx]) begin
            state_d    = LOCK;
            lock_src_d = grant_idx;
         end
         LOCK: if (xfer && in_last[grant_idx]) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // Outputs: mask requests to the locked source; rotate only at packet end.
   always_comb begin
      req         = in_valid;
      ptr_advance = xfer && in_last[grant_idx];
      if (state_q == LOCK) req = in_valid & (NUM_IN'(1) << lock_src_q);
   end
`else
   // Every flit competes on its own; in_last is only forwarded.
   always_comb begin
      req         = in_valid;
      ptr_advance = xfer;
   end
`endif

   // Next value of the priority pointer and the output stage.
   always_comb begin
      prio_ptr_d  = ptr_advance ? ptr_inc : prio_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = data_arr[grant_idx];
         out_last_d  = in_last[grant_idx];
         out_src_d   = grant_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Registers; reset discards any flit held in the output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_ptr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         prio_ptr_q  <= prio_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;

endmodule
